pwl_activation_simd: RTL

// - Multi-lane, multi-mode piecewise-linear activation unit for the SIMD datapath.
// - Applies sigmoid, tanh or hard-sigmoid to LANES signed fixed-point operands per transaction.
// - 3-stage pipeline with valid/ready flow control.
// - The binary point comes from immediate[5:0] and is captured per transaction.

---
 rtl/pwl_activation_simd_if.sv | 37 +++
 rtl/pwl_activation_simd.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_activation_simd_if.sv
// Valid/ready transaction bundle for the PWL activation unit.
// Producer side is master, the activation unit is slave.
interface pwl_activation_simd_if #(
  parameter int BIT_WIDTH = 32,
  parameter int LANES     = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*BIT_WIDTH-1:0] in_data;
  logic [1:0]                 in_mode;
  logic [31:0]                immediate;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*BIT_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output immediate,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  immediate,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pwl_activation_simd.sv
// 3-stage SIMD piecewise-linear sigmoid / tanh / hard-sigmoid unit.
// Define ACT_SAT_COUNT_EN to add the saturated-lane counter.
module pwl_activation_simd #(
  parameter int BIT_WIDTH = 32,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef ACT_SAT_COUNT_EN
  output logic [CNT_WIDTH-1:0] sat_count,
  input  logic                 sat_clear,
`endif
  pwl_activation_simd_if.slave bus
);
  localparam int BW = BIT_WIDTH;
  localparam int CW = BW + 5;

  localparam logic [BW-1:0] MAXP = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] MINN = {1'b1, {(BW-1){1'b0}}};

  localparam logic [1:0] M_SIG  = 2'b00;
  localparam logic [1:0] M_TANH = 2'b01;
  localparam logic [1:0] M_HARD = 2'b10;
  localparam logic [1:0] M_PASS = 2'b11;

  logic en;
  logic v1, v2, v3;

  // S1 inputs and combinational results
  logic [LANES-1:0][BW-1:0] x_in;
  logic [LANES-1:0][BW-1:0] a_in;
  logic [LANES-1:0][BW-1:0] u_in;
  logic [LANES-1:0]         s_in;
  logic [LANES-1:0]         lt1_in;
  logic [LANES-1:0]         lt2_in;
  logic [LANES-1:0]         lt5_in;
  logic [5:0]               f_in;
  logic [CW-1:0]            c1_in;
  logic [CW-1:0]            c2_in;
  logic [CW-1:0]            c5_in;
  logic                     unused_ok;

  // S1 registers
  logic [1:0]               m1;
  logic [5:0]               f1;
  logic [LANES-1:0][BW-1:0] x1;
  logic [LANES-1:0][BW-1:0] u1;
  logic [LANES-1:0]         s1;
  logic [LANES-1:0]         lt1_1;
  logic [LANES-1:0]         lt2_1;
  logic [LANES-1:0]         lt5_1;

  // S2 combinational
  logic [BW-1:0]            one1;
  logic [BW-1:0]            p50;
  logic [BW-1:0]            p625;
  logic [BW-1:0]            p84;
  logic [LANES-1:0][BW:0]   hs;
  logic [LANES-1:0][BW-1:0] y_n;

  // S2 registers
  logic [1:0]               m2;
  logic [5:0]               f2;
  logic [LANES-1:0][BW-1:0] x2;
  logic [LANES-1:0][BW-1:0] y2;
  logic [LANES-1:0]         s2;

  // S3 combinational and output register
  logic [BW-1:0]            one2;
  logic [LANES-1:0][BW-1:0] t_n;
  logic [LANES-1:0][BW-1:0] r_n;
  logic [LANES-1:0][BW-1:0] q3;

  assign en            = bus.out_ready | ~v3;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3;
  assign bus.out_data  = q3;

  assign x_in      = bus.in_data;
  assign f_in      = bus.immediate[5:0];
  assign unused_ok = ^bus.immediate[31:6];

  always_comb begin
    c1_in  = CW'(1) << f_in;
    c2_in  = (CW'(19) << f_in) >> 3;
    c5_in  = CW'(5) << f_in;
    a_in   = '0;
    u_in   = '0;
    s_in   = '0;
    lt1_in = '0;
    lt2_in = '0;
    lt5_in = '0;
    for (int i = 0; i < LANES; i++) begin
      s_in[i] = x_in[i][BW-1];
      if (!x_in[i][BW-1])
        a_in[i] = x_in[i];
      else if (x_in[i] == MINN)
        a_in[i] = MAXP;
      else
        a_in[i] = -x_in[i];
      // tanh(x) = 2*sigmoid(2x) - 1
      if (bus.in_mode != M_TANH)
        u_in[i] = a_in[i];
      else if (a_in[i][BW-2])
        u_in[i] = MAXP;
      else
        u_in[i] = a_in[i] << 1;
      lt1_in[i] = {5'b0, u_in[i]} < c1_in;
      lt2_in[i] = {5'b0, u_in[i]} < c2_in;
      lt5_in[i] = {5'b0, u_in[i]} < c5_in;
    end
  end

  always_comb begin
    one1 = BW'(CW'(1) << f1);
    p50  = BW'((CW'(16) << f1) >> 5);
    p625 = BW'((CW'(20) << f1) >> 5);
    p84  = BW'((CW'(27) << f1) >> 5);
    hs   = '0;
    y_n  = '0;
    for (int i = 0; i < LANES; i++) begin
      hs[i] = {1'b0, u1[i] >> 2} + {1'b0, p50};
      if (m1 == M_HARD)
        y_n[i] = (hs[i] > {1'b0, one1}) ? one1 : hs[i][BW-1:0];
      else if (lt1_1[i])
        y_n[i] = hs[i][BW-1:0];
      else if (lt2_1[i])
        y_n[i] = (u1[i] >> 3) + p625;
      else if (lt5_1[i])
        y_n[i] = (u1[i] >> 5) + p84;
      else
        y_n[i] = one1;
    end
  end

  always_comb begin
    one2 = BW'(CW'(1) << f2);
    t_n  = '0;
    r_n  = '0;
    for (int i = 0; i < LANES; i++) begin
      t_n[i] = (y2[i] << 1) - one2;
      unique case (m2)
        M_TANH:  r_n[i] = s2[i] ? -t_n[i] : t_n[i];
        M_PASS:  r_n[i] = x2[i];
        default: r_n[i] = s2[i] ? one2 - y2[i] : y2[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      m1    <= M_SIG;
      f1    <= '0;
      x1    <= '0;
      u1    <= '0;
      s1    <= '0;
      lt1_1 <= '0;
      lt2_1 <= '0;
      lt5_1 <= '0;
      m2    <= M_SIG;
      f2    <= '0;
      x2    <= '0;
      y2    <= '0;
      s2    <= '0;
      q3    <= '0;
    end else if (en) begin
      v1    <= bus.in_valid;
      m1    <= bus.in_mode;
      f1    <= f_in;
      x1    <= x_in;
      u1    <= u_in;
      s1    <= s_in;
      lt1_1 <= lt1_in;
      lt2_1 <= lt2_in;
      lt5_1 <= lt5_in;
      v2    <= v1;
      m2    <= m1;
      f2    <= f1;
      x2    <= x1;
      y2    <= y_n;
      s2    <= s1;
      v3    <= v2;
      q3    <= r_n;
    end
  end

`ifdef ACT_SAT_COUNT_EN
  localparam int CW1 = CNT_WIDTH + 1;

  logic [LANES-1:0]   sat2;
  logic [CW1-1:0]     inc;
  logic [CW1-1:0]     sum;
  logic [CNT_WIDTH-1:0] cnt;
  logic               cnt_beat;

  assign sat_count = cnt;
  assign cnt_beat  = en & v2 & ((m2 == M_SIG) | (m2 == M_TANH));

  always_comb begin
    inc = '0;
    for (int i = 0; i < LANES; i++)
      inc = inc + CW1'(sat2[i]);
    if (!cnt_beat)
      inc = '0;
    sum = {1'b0, cnt} + inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat2 <= '0;
      cnt  <= '0;
    end else begin
      if (en)
        sat2 <= ~lt5_1;
      if (sat_clear)
        cnt <= '0;
      else if (sum[CNT_WIDTH])
        cnt <= '1;
      else
        cnt <= sum[CNT_WIDTH-1:0];
    end
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule
